// File: rtl/oram_bucket_server.sv
// oram_bucket_server: ORAM tree bucket store serving root-first path reads, path write-backs and tree clears
module oram_bucket_server #(
  parameter int A = 8,
  parameter int D = 6,
  parameter int K = 3,
  localparam int NODES = 2**D - 1,
  localparam int ENTRIES = NODES * K,
  localparam int TW = (D - 1) + D + 8 * A + 3,
  localparam int LW = $clog2(D),
  localparam int SW = $clog2(K),
  localparam int IW = $clog2(ENTRIES),
  localparam int OW = $clog2(ENTRIES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [D-2:0]  req_leaf,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [TW-1:0] rd_data,
  output logic [LW-1:0] rd_level,
  output logic [SW-1:0] rd_slot,
  output logic          rd_last,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [TW-1:0] wr_data,
  input  logic          wr_last,
  output logic          busy,
  output logic [OW-1:0] occ,
  output logic          protocol_err
);
  typedef enum logic [1:0] {IDLE, RD, WR, CLR} state_t;
  state_t state;
  logic [TW-1:0] mem [ENTRIES];
  logic [D-2:0] leaf, lf_sh;
  logic [LW-1:0] cur_lvl, nxt_lvl;
  logic [SW-1:0] cur_slot, nxt_slot;
  logic [D-1:0] cur_node, nxt_node;
  logic [IW-1:0] cur_idx, nxt_idx, clr_idx;
  logic wrap, is_last, nxt_last;
  logic [OW-1:0] occ_nxt;
  // path walker: current beat position, the following beat, and the occupancy after a write
  always_comb begin
    lf_sh = leaf >> cur_lvl;
    wrap = cur_slot == SW'(K - 1);
    nxt_slot = wrap ? '0 : cur_slot + 1'b1;
    nxt_lvl = wrap ? cur_lvl + 1'b1 : cur_lvl;
    nxt_node = wrap ? {cur_node[D-2:0], lf_sh[0]} : cur_node;
    is_last = wrap && cur_lvl == LW'(D - 1);
    nxt_last = nxt_slot == SW'(K - 1) && nxt_lvl == LW'(D - 1);
    cur_idx = IW'(cur_node - 1'b1) * IW'(K) + IW'(cur_slot);
    nxt_idx = IW'(nxt_node - 1'b1) * IW'(K) + IW'(nxt_slot);
    occ_nxt = occ + OW'(wr_data[TW-1]) - OW'(mem[cur_idx][TW-1]);
  end
  // request FSM with storage, registered read beats and occupancy tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      for (int i = 0; i < ENTRIES; i++) mem[i] <= '0;
      leaf <= '0;
      cur_lvl <= '0;
      cur_slot <= '0;
      cur_node <= D'(1);
      clr_idx <= '0;
      req_ready <= 1'b1;
      rd_valid <= 1'b0;
      wr_ready <= 1'b0;
      busy <= 1'b0;
      occ <= '0;
      protocol_err <= 1'b0;
      rd_data <= '0;
      rd_level <= '0;
      rd_slot <= '0;
      rd_last <= 1'b0;
    end else begin
      protocol_err <= 1'b0;
      case (state)
        IDLE: if (req_valid && req_op != 2'b11) begin
          leaf <= req_leaf;
          cur_lvl <= '0;
          cur_slot <= '0;
          cur_node <= D'(1);
          clr_idx <= '0;
          req_ready <= 1'b0;
          busy <= 1'b1;
          if (req_op == 2'b00) begin
            state <= RD;
            rd_valid <= 1'b1;
            rd_data <= mem[0];
            rd_level <= '0;
            rd_slot <= '0;
            rd_last <= 1'b0;
          end else if (req_op == 2'b01) begin
            state <= WR;
            wr_ready <= 1'b1;
          end else begin
            state <= CLR;
          end
        end
        RD: if (rd_ready) begin
          if (rd_last) begin
            state <= IDLE;
            rd_valid <= 1'b0;
            rd_last <= 1'b0;
            req_ready <= 1'b1;
            busy <= 1'b0;
          end else begin
            cur_lvl <= nxt_lvl;
            cur_slot <= nxt_slot;
            cur_node <= nxt_node;
            rd_data <= mem[nxt_idx];
            rd_level <= nxt_lvl;
            rd_slot <= nxt_slot;
            rd_last <= nxt_last;
          end
        end
        WR: if (wr_valid) begin
          mem[cur_idx] <= wr_data;
          occ <= occ_nxt;
          protocol_err <= wr_last != is_last;
          cur_lvl <= nxt_lvl;
          cur_slot <= nxt_slot;
          cur_node <= nxt_node;
          if (is_last) begin
            state <= IDLE;
            wr_ready <= 1'b0;
            req_ready <= 1'b1;
            busy <= 1'b0;
          end
        end
        CLR: begin
          mem[clr_idx] <= '0;
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == IW'(ENTRIES - 1)) begin
            state <= IDLE;
            occ <= '0;
            req_ready <= 1'b1;
            busy <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_oram_bucket_server.sv
// tb_oram_bucket_server: directed and randomized path traffic checked against a flat tuple-array model
module tb_oram_bucket_server;
  logic clk = 0, rst = 1;
  logic req_valid = 0, rd_ready = 0, wr_valid = 0, wr_last = 0;
  logic [1:0] req_op = 0;
  logic [4:0] req_leaf = 0;
  logic [77:0] wr_data = 0;
  logic req_ready, rd_valid, rd_last, wr_ready, busy, protocol_err;
  logic [77:0] rd_data;
  logic [2:0] rd_level;
  logic [1:0] rd_slot;
  logic [7:0] occ;
  logic [77:0] mm [189];
  int errors = 0, checks = 0;

  oram_bucket_server dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_leaf(req_leaf), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_level(rd_level), .rd_slot(rd_slot), .rd_last(rd_last), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_data(wr_data), .wr_last(wr_last), .busy(busy), .occ(occ),
    .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pidx(input logic [4:0] lf, input int b);
    int node = 1;
    for (int i = 0; i < b / 3; i++) node = 2 * node + int'(lf[i]);
    return (node - 1) * 3 + b % 3;
  endfunction

  function automatic int model_occ();
    int n = 0;
    for (int i = 0; i < 189; i++) n += int'(mm[i][77]);
    return n;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 189; i++) mm[i] = '0;
  endtask

  task automatic start(input logic [1:0] op, input logic [4:0] lf);
    int n = 0;
    while (!req_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", req_ready, 1);
    req_valid = 1;
    req_op = op;
    req_leaf = lf;
    @(negedge clk);
    req_valid = 0;
  endtask

  task automatic read_path(input logic [4:0] lf, input int mode);
    int b = 0, cyc = 0;
    start(2'b00, lf);
    while (b < 18 && cyc < 200) begin
      chk("rd_valid", rd_valid, 1);
      chk("rd_data", rd_data, mm[pidx(lf, b)]);
      chk("rd_level", rd_level, b / 3);
      chk("rd_slot", rd_slot, b % 3);
      chk("rd_last", rd_last, b == 17);
      chk("rd_busy", busy, 1);
      rd_ready = (mode == 0) || (mode == 1 && cyc % 2 == 0) || (mode == 2 && $urandom_range(0, 1) == 1);
      if (rd_ready) b++;
      cyc++;
      @(negedge clk);
    end
    rd_ready = 0;
    chk("rd_beats", b, 18);
    chk("rd_done_valid", rd_valid, 0);
    chk("rd_done_req_ready", req_ready, 1);
    chk("rd_occ", occ, model_occ());
  endtask

  task automatic write_path(input logic [4:0] lf, input int last_at, input int gaps, input int bn_seq, output int perr_n);
    int b = 0, cyc = 0;
    bit ep = 0;
    perr_n = 0;
    start(2'b01, lf);
    while (cyc < 300) begin
      chk("protocol_err", protocol_err, ep);
      perr_n += int'(protocol_err);
      ep = 0;
      if (b == 18) break;
      chk("wr_ready", wr_ready, 1);
      wr_valid = gaps == 0 || $urandom_range(0, 3) != 0;
      wr_data = {bn_seq != 0 ? 1'b1 : 1'($urandom_range(0, 3) != 0), 1'($urandom), 5'($urandom),
                 bn_seq != 0 ? 6'(b) : 6'($urandom), 1'($urandom), $urandom, $urandom};
      wr_last = b == last_at || b == 17;
      if (wr_valid) begin
        mm[pidx(lf, b)] = wr_data;
        ep = wr_last != (b == 17);
        b++;
      end
      cyc++;
      @(negedge clk);
    end
    wr_valid = 0;
    wr_last = 0;
    chk("wr_beats", b, 18);
    chk("wr_done_ready", wr_ready, 0);
    chk("wr_done_busy", busy, 0);
    chk("wr_done_req_ready", req_ready, 1);
    chk("wr_occ", occ, model_occ());
  endtask

  task automatic clear_tree();
    int n = 0;
    start(2'b10, 5'd0);
    chk("clr_req_ready", req_ready, 0);
    while (busy && n < 400) begin
      n++;
      @(negedge clk);
    end
    model_clear();
    chk("clr_busy_cycles", n, 189);
    chk("clr_occ", occ, 0);
    chk("clr_req_ready_after", req_ready, 1);
  endtask

  initial begin
    int perr, b;
    logic [4:0] lf;
    model_clear();
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_occ", occ, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_perr", protocol_err, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_last", rd_last, 0);
    req_valid = 1;
    req_op = 2'b11;
    repeat (3) begin
      @(negedge clk);
      chk("op11_busy", busy, 0);
      chk("op11_req_ready", req_ready, 1);
      chk("op11_rd_valid", rd_valid, 0);
      chk("op11_wr_ready", wr_ready, 0);
    end
    req_valid = 0;
    read_path(5'b00000, 0);
    write_path(5'b10110, 17, 0, 1, perr);
    chk("t2_occ", occ, 18);
    chk("t2_perr_count", perr, 0);
    read_path(5'b10110, 0);
    read_path(5'b00110, 0);
    read_path(5'b10110, 1);
    write_path(5'b01001, 10, 1, 0, perr);
    chk("t4_perr_count", perr, 1);
    read_path(5'b01001, 2);
    clear_tree();
    read_path(5'b10110, 0);
    repeat (4) begin
      lf = 5'($urandom);
      write_path(lf, 17, 1, 0, perr);
      chk("rand_perr_count", perr, 0);
      read_path(lf, 2);
      read_path(5'($urandom), 2);
    end
    start(2'b00, 5'b10110);
    b = 0;
    while (b < 7) begin
      rd_ready = 1;
      @(negedge clk);
      b++;
    end
    rd_ready = 0;
    chk("t6_level_before_rst", rd_level, 2);
    chk("t6_slot_before_rst", rd_slot, 1);
    rst = 1;
    @(negedge clk);
    chk("t6_rd_valid", rd_valid, 0);
    chk("t6_req_ready", req_ready, 1);
    chk("t6_occ", occ, 0);
    chk("t6_busy", busy, 0);
    chk("t6_rd_last", rd_last, 0);
    rst = 0;
    model_clear();
    @(negedge clk);
    read_path(5'b10110, 2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
